// File: rtl/dmem_fill_if.sv
// Signal bundle between the data-cache miss-fill controller, the pipeline/cache
// and main memory. The master side is the fill controller.
interface dmem_fill_if;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        fsm_busy;
    logic        mem_enable;
    logic [15:0] memory_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        write_data_array;
    logic [15:0] data_word_addr;
    logic [15:0] cache_data;
    logic        write_tag_array;
    logic [15:0] tag_address;
    logic [15:0] miss_count;

    modport master (
        input  miss_detected, miss_address, memory_data_valid, memory_data,
        output fsm_busy, mem_enable, memory_address, write_data_array,
               data_word_addr, cache_data, write_tag_array, tag_address, miss_count
    );

    modport slave (
        output miss_detected, miss_address, memory_data_valid, memory_data,
        input  fsm_busy, mem_enable, memory_address, write_data_array,
               data_word_addr, cache_data, write_tag_array, tag_address, miss_count
    );
endinterface

// File: rtl/dmem_fill_fsm.sv
// Data-cache miss-fill controller: stalls the pipeline, streams one block from
// main memory into the data array, writes the tag, and counts fills.
module dmem_fill_fsm #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int CNT_W           = $clog2(WORDS_PER_BLOCK)
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_fill_if.master bus
);
    typedef enum logic [1:0] {IDLE, FILL, WAIT} state_t;

    localparam logic [CNT_W-1:0] LAST     = CNT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [15:0]      BLK_MASK = ~16'(2 * WORDS_PER_BLOCK - 1);

    state_t           state;
    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] recv_cnt;
    logic [15:0]      base;
    logic [15:0]      miss_cnt;
    logic             ret;
    logic             last_ret;
    logic [15:0]      issue_off;
    logic [15:0]      recv_off;

    // Returns only count while a fill is open; stale ones in IDLE are dropped.
    assign ret       = (state != IDLE) && bus.memory_data_valid;
    assign last_ret  = ret && (recv_cnt == LAST);
    assign issue_off = 16'({issue_cnt, 1'b0});
    assign recv_off  = 16'({recv_cnt, 1'b0});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            base      <= '0;
            miss_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.miss_detected) begin
                        base      <= bus.miss_address & BLK_MASK;
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                        state     <= FILL;
                        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
                    end
                end
                FILL, WAIT: begin
                    if (state == FILL) begin
                        issue_cnt <= issue_cnt + 1'b1;
                        if (issue_cnt == LAST) state <= WAIT;
                    end
                    if (ret) recv_cnt <= recv_cnt + 1'b1;
                    // Completion wins over FILL->WAIT when memory has zero gap.
                    if (last_ret) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are gated by reset so an asserted reset silences everything at once.
    always_comb begin
        bus.fsm_busy         = 1'b0;
        bus.mem_enable       = 1'b0;
        bus.memory_address   = '0;
        bus.write_data_array = 1'b0;
        bus.data_word_addr   = '0;
        bus.cache_data       = '0;
        bus.write_tag_array  = 1'b0;
        bus.tag_address      = '0;
        if (rst_n) begin
            if (state == IDLE) begin
                bus.fsm_busy = bus.miss_detected;
            end else begin
                bus.fsm_busy = 1'b1;
                if (state == FILL) begin
                    bus.mem_enable     = 1'b1;
                    bus.memory_address = base + issue_off;
                end
                if (ret) begin
                    bus.write_data_array = 1'b1;
                    bus.data_word_addr   = base + recv_off;
                    bus.cache_data       = bus.memory_data;
                end
                if (last_ret) begin
                    bus.write_tag_array = 1'b1;
                    bus.tag_address     = base;
                end
            end
        end
    end

    assign bus.miss_count = miss_cnt;
endmodule

// File: tb/tb_dmem_fill_fsm.sv
// Scoreboard bench for dmem_fill_fsm: a latency/gap memory model plus a monitor
// that pops expected requests, data writes and tag writes as the DUT emits them.
module tb_dmem_fill_fsm;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_fill_if bus();

    dmem_fill_fsm #(.WORDS_PER_BLOCK(8), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_pass = 0;

    // scoreboard
    logic [15:0] req_q[$];
    logic [31:0] wr_q[$];
    logic [15:0] tag_q[$];
    int req_seen = 0;
    int wr_seen  = 0;
    int tag_seen = 0;
    logic [15:0] exp_cnt = 16'd0;
    logic [15:0] m_e16;
    logic [31:0] m_e32;

    // memory model
    longint cyc = 0;
    longint last_due = -1;
    longint m_due;
    int lat = 4;
    int max_gap = 0;
    logic [15:0] dbase = 16'h0;
    logic [15:0] pa_q[$];
    longint pd_q[$];
    logic [15:0] m_a;

    always @(negedge clk) begin
        if (bus.mem_enable) begin
            m_due = cyc + lat;
            if (m_due <= last_due) m_due = last_due + 1;
            if (max_gap > 0) m_due = m_due + longint'($urandom_range(max_gap, 0));
            last_due = m_due;
            pa_q.push_back(bus.memory_address);
            pd_q.push_back(m_due);
        end
    end

    initial begin
        bus.memory_data_valid = 1'b0;
        bus.memory_data = 16'h0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (pd_q.size() > 0 && pd_q[0] <= cyc) begin
                m_a = pa_q.pop_front();
                void'(pd_q.pop_front());
                bus.memory_data_valid = 1'b1;
                bus.memory_data = dbase + 16'(m_a[3:1]);
            end else begin
                bus.memory_data_valid = 1'b0;
                bus.memory_data = 16'h0;
            end
        end
    end

    // monitor: every DUT transaction must match the head of its queue
    always @(negedge clk) begin
        if (bus.mem_enable) begin
            req_seen++;
            n_chk++;
            if (req_q.size() == 0) $display("FAIL req_addr: got %h, none expected", bus.memory_address);
            else begin
                m_e16 = req_q.pop_front();
                if (bus.memory_address !== m_e16) $display("FAIL req_addr: got %h, want %h", bus.memory_address, m_e16);
                else n_pass++;
            end
        end
        if (bus.write_data_array) begin
            wr_seen++;
            n_chk++;
            if (wr_q.size() == 0) $display("FAIL data_write: got %h/%h, none expected", bus.data_word_addr, bus.cache_data);
            else begin
                m_e32 = wr_q.pop_front();
                if ({bus.data_word_addr, bus.cache_data} !== m_e32)
                    $display("FAIL data_write: got addr/data %h/%h, want %h/%h", bus.data_word_addr, bus.cache_data, m_e32[31:16], m_e32[15:0]);
                else n_pass++;
            end
        end
        if (bus.write_tag_array) begin
            tag_seen++;
            n_chk++;
            if (tag_q.size() == 0) $display("FAIL tag_write: got %h, none expected", bus.tag_address);
            else begin
                m_e16 = tag_q.pop_front();
                if (bus.tag_address !== m_e16 || bus.fsm_busy !== 1'b1)
                    $display("FAIL tag_write: got tag %h busy %b, want %h busy 1", bus.tag_address, bus.fsm_busy, m_e16);
                else n_pass++;
            end
        end
    end

    task automatic push_fill(input logic [15:0] a);
        logic [15:0] b;
        b = a & 16'hFFF0;
        for (int i = 0; i < 8; i++) begin
            req_q.push_back(b + 16'(2 * i));
            wr_q.push_back({b + 16'(2 * i), dbase + 16'(i)});
        end
        tag_q.push_back(b);
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic start_miss(input logic [15:0] a);
        push_fill(a);
        @(posedge clk); #1;
        bus.miss_detected = 1'b1;
        bus.miss_address = a;
        @(posedge clk); #1;
        bus.miss_detected = 1'b0;
    endtask

    task automatic wait_tags(input int target, input int budget, output bit ok);
        int n;
        n = 0;
        while (tag_seen < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        ok = (tag_seen >= target);
    endtask

    task automatic test_reset;
        bit ok;
        bus.miss_detected = 1'b1;
        bus.miss_address = 16'h1236;
        repeat (2) @(negedge clk);
        #1;
        n_chk++;
        if ({bus.fsm_busy, bus.mem_enable, bus.write_data_array, bus.write_tag_array} !== 4'b0)
            $display("FAIL reset_ctrl: got %b, want 0000", {bus.fsm_busy, bus.mem_enable, bus.write_data_array, bus.write_tag_array});
        else n_pass++;
        n_chk++;
        if ({bus.memory_address, bus.data_word_addr, bus.tag_address, bus.miss_count} !== 64'h0)
            $display("FAIL reset_data: got %h %h %h %h, want 0", bus.memory_address, bus.data_word_addr, bus.tag_address, bus.miss_count);
        else n_pass++;
        lat = 4; dbase = 16'h5000;
        push_fill(16'h1236);
        rst_n = 1'b1;
        #1;
        n_chk++;
        if (bus.fsm_busy !== 1'b1) $display("FAIL idle_stall: got %b, want 1", bus.fsm_busy);
        else n_pass++;
        @(posedge clk); #1;
        bus.miss_detected = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); #1;
            n_chk++;
            if (bus.mem_enable !== (i < 8)) $display("FAIL req_burst[%0d]: got %b, want %b", i, bus.mem_enable, (i < 8));
            else n_pass++;
        end
        wait_tags(1, 40, ok);
        n_chk++;
        if (!ok) $display("FAIL first_fill_tag: got %0d tags, want 1", tag_seen);
        else n_pass++;
        @(negedge clk); #1;
        n_chk++;
        if (bus.fsm_busy !== 1'b0 || bus.miss_count !== exp_cnt)
            $display("FAIL first_fill_end: got busy %b cnt %h, want 0 %h", bus.fsm_busy, bus.miss_count, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        bit ok;
        int t0;
        t0 = tag_seen;
        lat = 2; dbase = 16'h1100;
        push_fill(16'h00F2);
        push_fill(16'hFFFE);
        @(posedge clk); #1;
        bus.miss_detected = 1'b1;
        bus.miss_address = 16'h00F2;
        @(posedge clk); #1;
        bus.miss_address = 16'hFFFE;
        wait_tags(t0 + 1, 40, ok);
        n_chk++;
        if (!ok) $display("FAIL b2b_first_tag: got %0d tags, want %0d", tag_seen, t0 + 1);
        else n_pass++;
        @(negedge clk); #1;
        n_chk++;
        if (bus.fsm_busy !== 1'b1 || bus.mem_enable !== 1'b0)
            $display("FAIL b2b_idle_cycle: got busy %b men %b, want 1 0", bus.fsm_busy, bus.mem_enable);
        else n_pass++;
        @(posedge clk); #1;
        bus.miss_detected = 1'b0;
        @(negedge clk); #1;
        n_chk++;
        if (bus.mem_enable !== 1'b1) $display("FAIL b2b_restart: got men %b, want 1", bus.mem_enable);
        else n_pass++;
        wait_tags(t0 + 2, 40, ok);
        n_chk++;
        if (!ok) $display("FAIL b2b_second_tag: got %0d tags, want %0d", tag_seen, t0 + 2);
        else n_pass++;
        @(negedge clk); #1;
        n_chk++;
        if (bus.fsm_busy !== 1'b0 || bus.miss_count !== exp_cnt || req_q.size() != 0 || wr_q.size() != 0)
            $display("FAIL b2b_end: got busy %b cnt %h left %0d/%0d, want 0 %h 0/0", bus.fsm_busy, bus.miss_count, req_q.size(), wr_q.size(), exp_cnt);
        else n_pass++;
    endtask

    task automatic test_gapped;
        int t0;
        int n;
        t0 = tag_seen;
        lat = 2; max_gap = 3; dbase = 16'hA000;
        start_miss(16'h4A5C);
        n = 0;
        while (tag_seen == t0 && n < 80) begin
            @(negedge clk); #1;
            n++;
            n_chk++;
            if (bus.fsm_busy !== 1'b1) $display("FAIL gap_busy: got %b at cycle %0d, want 1", bus.fsm_busy, n);
            else n_pass++;
        end
        n_chk++;
        if (tag_seen != t0 + 1) $display("FAIL gap_tag: got %0d tags, want %0d", tag_seen, t0 + 1);
        else n_pass++;
        @(negedge clk); #1;
        max_gap = 0;
        n_chk++;
        if (bus.fsm_busy !== 1'b0 || wr_q.size() != 0) $display("FAIL gap_end: got busy %b left %0d, want 0 0", bus.fsm_busy, wr_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_midfill;
        bit ok;
        int w0;
        int t0;
        int n;
        lat = 3; dbase = 16'h7700;
        w0 = wr_seen;
        t0 = tag_seen;
        start_miss(16'h2468);
        n = 0;
        while (wr_seen < w0 + 3 && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({bus.fsm_busy, bus.mem_enable, bus.write_data_array, bus.write_tag_array} !== 4'b0 ||
            {bus.memory_address, bus.data_word_addr, bus.cache_data, bus.tag_address, bus.miss_count} !== 80'h0)
            $display("FAIL midfill_reset_out: got ctrl %b addr %h wr %h/%h cnt %h, want all 0",
                     {bus.fsm_busy, bus.mem_enable, bus.write_data_array, bus.write_tag_array},
                     bus.memory_address, bus.data_word_addr, bus.cache_data, bus.miss_count);
        else n_pass++;
        req_q.delete(); wr_q.delete(); tag_q.delete();
        exp_cnt = 16'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        while (pd_q.size() != 0 && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        repeat (2) @(negedge clk);
        #1;
        n_chk++;
        if (wr_seen != w0 + 3 || tag_seen != t0 || bus.miss_count !== 16'h0 || pd_q.size() != 0)
            $display("FAIL midfill_ignored: got writes %0d tags %0d cnt %h, want %0d %0d 0", wr_seen - w0, tag_seen - t0, bus.miss_count, 3, 0);
        else n_pass++;
        dbase = 16'h7800;
        start_miss(16'h2468);
        wait_tags(t0 + 1, 40, ok);
        @(negedge clk); #1;
        n_chk++;
        if (!ok || bus.fsm_busy !== 1'b0 || bus.miss_count !== exp_cnt || wr_q.size() != 0)
            $display("FAIL midfill_refill: got tag %b busy %b cnt %h left %0d, want 1 0 %h 0", ok, bus.fsm_busy, bus.miss_count, wr_q.size(), exp_cnt);
        else n_pass++;
    endtask

    task automatic test_spurious;
        bit ok;
        int w0;
        int t0;
        lat = 2; dbase = 16'h3300;
        w0 = wr_seen;
        t0 = tag_seen;
        pa_q.push_back(16'h0002); pd_q.push_back(cyc + 1);
        pa_q.push_back(16'h0004); pd_q.push_back(cyc + 2);
        last_due = cyc + 2;
        repeat (4) @(negedge clk);
        #1;
        n_chk++;
        if (wr_seen != w0 || bus.fsm_busy !== 1'b0) $display("FAIL idle_valid: got writes %0d busy %b, want 0 0", wr_seen - w0, bus.fsm_busy);
        else n_pass++;
        start_miss(16'h3338);
        @(posedge clk); #1;
        bus.miss_detected = 1'b1;
        bus.miss_address = 16'h7770;
        repeat (2) @(posedge clk);
        #1;
        bus.miss_detected = 1'b0;
        wait_tags(t0 + 1, 40, ok);
        n_chk++;
        if (!ok) $display("FAIL overlap_tag: got %0d tags, want %0d", tag_seen - t0, 1);
        else n_pass++;
        @(negedge clk); #1;
        n_chk++;
        if (bus.fsm_busy !== 1'b0 || bus.miss_count !== exp_cnt || req_q.size() != 0 || tag_q.size() != 0)
            $display("FAIL overlap_end: got busy %b cnt %h, want 0 %h", bus.fsm_busy, bus.miss_count, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_saturation;
        bit ok;
        @(negedge clk); #1;
        force dut.miss_cnt = 16'hFFFE;
        #1 release dut.miss_cnt;
        exp_cnt = 16'hFFFE;
        lat = 1; dbase = 16'h0C00;
        for (int k = 0; k < 3; k++) begin
            start_miss(16'h0800 + 16'(k * 16));
            wait_tags(tag_seen + 1, 40, ok);
            @(negedge clk); #1;
            n_chk++;
            if (!ok || bus.miss_count !== exp_cnt || bus.miss_count !== 16'hFFFF)
                $display("FAIL saturate[%0d]: got tag %b cnt %h, want 1 ffff", k, ok, bus.miss_count);
            else n_pass++;
        end
    endtask

    initial begin
        bus.miss_detected = 1'b0;
        bus.miss_address = 16'h0;
        test_reset();
        test_back_to_back();
        test_gapped();
        test_reset_midfill();
        test_spurious();
        test_saturation();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end
endmodule
